// File: rtl/event_any_waiter_pkg.sv
// Shared definitions for event_any_waiter: parameter defaults and FSM state codes.
package event_any_waiter_pkg;

  localparam int NUM_EVENTS_DEF = 3;
  localparam int DELAY_W_DEF    = 8;
  localparam int TIMEOUT_W_DEF  = 16;
  localparam int ROUND_W_DEF    = 8;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/event_down_counter.sv
// Loadable down counter that saturates at zero and flags when it is there.
module event_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down while enabled, stopping at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/event_any_waiter.sv
// event_any_waiter: arm a wait on a set of event channels, optionally after a
// pre-wait delay and bounded by a timeout; report which masked channels fired
// first (multi-hot) or that the timeout expired.
// Optional build macro EVENT_ANY_WAITER_LATCH_EN: masked events seen during the
// delay phase are remembered and complete the wait on its first cycle.
module event_any_waiter
  import event_any_waiter_pkg::*;
#(
  parameter int NUM_EVENTS = NUM_EVENTS_DEF,
  parameter int DELAY_W    = DELAY_W_DEF,
  parameter int TIMEOUT_W  = TIMEOUT_W_DEF,
  parameter int ROUND_W    = ROUND_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] ev_i,
  input  logic                  arm_valid,
  output logic                  arm_ready,
  input  logic [NUM_EVENTS-1:0] arm_mask,
  input  logic [DELAY_W-1:0]    arm_delay,
  input  logic [TIMEOUT_W-1:0]  arm_timeout,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [NUM_EVENTS-1:0] done_hit,
  output logic                  done_timeout,
  output logic                  busy,
  output logic [ROUND_W-1:0]    rounds
);

  logic [1:0]            state;
  logic [NUM_EVENTS-1:0] mask_q;
  logic                  tmo_en;
  logic                  arm_fire;
  logic                  dly_zero;
  logic                  tmo_zero;
  logic [NUM_EVENTS-1:0] hit;

  assign arm_fire = (state == ST_IDLE) && arm_valid;

  // Both counters are loaded with (value - 1) so that reaching zero marks the
  // last cycle of the phase: delay d spends d cycles in DELAY, timeout t spends
  // t cycles in WAIT. A zero delay never enters DELAY, so its wrapped load is unused.
  event_down_counter #(.W(DELAY_W)) u_delay_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (arm_fire),
    .load_val (arm_delay - DELAY_W'(1)),
    .en       (state == ST_DELAY),
    .zero     (dly_zero)
  );

  event_down_counter #(.W(TIMEOUT_W)) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (arm_fire),
    .load_val (arm_timeout - TIMEOUT_W'(1)),
    .en       ((state == ST_WAIT) && tmo_en),
    .zero     (tmo_zero)
  );

`ifdef EVENT_ANY_WAITER_LATCH_EN
  logic [NUM_EVENTS-1:0] pending;

  // Sticky record of masked events seen while still in DELAY; cleared on arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (arm_fire) begin
      pending <= '0;
    end else if (state == ST_DELAY) begin
      pending <= pending | (ev_i & mask_q);
    end
  end

  assign hit = (ev_i & mask_q) | pending;
`else
  assign hit = ev_i & mask_q;
`endif

  // Main sequencer: arm, delay, wait for hit or timeout, hold result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      mask_q       <= '0;
      tmo_en       <= 1'b0;
      done_hit     <= '0;
      done_timeout <= 1'b0;
      rounds       <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // here samples the pre-edge values, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (arm_valid) begin
            mask_q <= arm_mask;
            tmo_en <= (arm_timeout != '0);
            state  <= (arm_delay == '0) ? ST_WAIT : ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (dly_zero) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A hit in the expiry cycle is reported as a hit, not a timeout
          if (hit != '0) begin
            done_hit     <= hit;
            done_timeout <= 1'b0;
            state        <= ST_DONE;
          end else if (tmo_en && tmo_zero) begin
            done_hit     <= '0;
            done_timeout <= 1'b1;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            rounds <= rounds + ROUND_W'(1);
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign arm_ready  = (state == ST_IDLE);
  assign done_valid = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_event_any_waiter.sv
// Self-checking bench for event_any_waiter: directed table of rounds, reset
// mid-wait, then randomized rounds checked against a schedule-scanning model.
module tb_event_any_waiter;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int TW   = 16;
  localparam int RW   = 2;
  localparam int MAXK = 400;

  logic          clk;
  logic          rst;
  logic [N-1:0]  ev_i;
  logic          arm_valid;
  logic          arm_ready;
  logic [N-1:0]  arm_mask;
  logic [DW-1:0] arm_delay;
  logic [TW-1:0] arm_timeout;
  logic          done_valid;
  logic          done_ready;
  logic [N-1:0]  done_hit;
  logic          done_timeout;
  logic          busy;
  logic [RW-1:0] rounds;

  int checks   = 0;
  int failures = 0;
  int exp_rounds = 0;

  // Event schedule for one round: index k = k-th clock edge after the arm edge
  logic [N-1:0] ev_seq [0:MAXK];

  event_any_waiter #(
    .NUM_EVENTS (N),
    .DELAY_W    (DW),
    .TIMEOUT_W  (TW),
    .ROUND_W    (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ev_i         (ev_i),
    .arm_valid    (arm_valid),
    .arm_ready    (arm_ready),
    .arm_mask     (arm_mask),
    .arm_delay    (arm_delay),
    .arm_timeout  (arm_timeout),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_hit     (done_hit),
    .done_timeout (done_timeout),
    .busy         (busy),
    .rounds       (rounds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seq();
    for (int k = 0; k <= MAXK; k++) ev_seq[k] = '0;
  endtask

  // Reference: scan the schedule. Edges 1..d are the delay phase, the wait
  // starts at edge d+1; first masked event wins, else expiry at edge d+t.
  task automatic model(input logic [N-1:0] m, input int d, input int t,
                       output int ek, output logic [N-1:0] h, output logic to);
    logic [N-1:0] pend;
    logic [N-1:0] x;
    pend = '0;
    ek = -1;
    h  = '0;
    to = 1'b0;
    for (int k = 1; k <= d; k++) pend = pend | (ev_seq[k] & m);
    for (int k = d + 1; k <= MAXK; k++) begin
      if (ek < 0) begin
        x = ev_seq[k] & m;
`ifdef EVENT_ANY_WAITER_LATCH_EN
        if (k == d + 1) x = x | pend;
`endif
        if (x != '0) begin
          ek = k; h = x; to = 1'b0;
        end else if (t != 0 && (k - d) == t) begin
          ek = k; h = '0; to = 1'b1;
        end
      end
    end
  endtask

  // One arm/complete round driven from ev_seq, checked against given expectations
  task automatic do_round(input string name, input logic [N-1:0] m, input int d, input int t,
                          input logic [N-1:0] ehit, input logic eto, input int ek, input int hold);
    int first;
    check({name, " arm_ready"}, 32'(arm_ready), 32'd1);
    arm_valid   = 1'b1;
    arm_mask    = m;
    arm_delay   = DW'(d);
    arm_timeout = TW'(t);
    ev_i        = ev_seq[0];
    tick();
    arm_valid = 1'b0;
    check({name, " busy"}, 32'(busy), 32'd1);
    first = -1;
    for (int k = 1; k <= ek; k++) begin
      ev_i = ev_seq[k];
      tick();
      if (done_valid === 1'b1 && first < 0) first = k;
    end
    ev_i = '0;
    check({name, " latency"}, 32'(first), 32'(ek));
    check({name, " done_hit"}, 32'(done_hit), 32'(ehit));
    check({name, " done_timeout"}, 32'(done_timeout), 32'(eto));
    check({name, " arm_ready_done"}, 32'(arm_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      ev_i = N'($urandom);
      tick();
    end
    ev_i = '0;
    check({name, " held_valid"}, 32'(done_valid), 32'd1);
    check({name, " held_hit"}, 32'(done_hit), 32'(ehit));
    check({name, " held_timeout"}, 32'(done_timeout), 32'(eto));
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    exp_rounds = (exp_rounds + 1) % (1 << RW);
    check({name, " rounds"}, 32'(rounds), 32'(exp_rounds));
    check({name, " idle"}, {30'd0, done_valid, busy}, 32'd0);
  endtask

  typedef struct {
    string        name;
    logic [N-1:0] m;
    int           d;
    int           t;
    int           k1;
    logic [N-1:0] v1;
    int           k2;
    logic [N-1:0] v2;
    logic [N-1:0] ehit;
    logic         eto;
    int           ek;
    int           hold;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int ek;
    logic [N-1:0] h;
    logic to;
    int d, t;
    logic [N-1:0] m;
`ifdef EVENT_ANY_WAITER_LATCH_EN
    localparam int EDGE_EK = 6;
`else
    localparam int EDGE_EK = 9;
`endif

    //          name            mask    d   t   k1   v1      k2  v2      hit     to    ek       hold
    tbl[0] = '{"seq_ev0",      3'b111, 10, 0, 100, 3'b001, 0,  3'b000, 3'b001, 1'b0, 100,     0};
    tbl[1] = '{"seq_ev1",      3'b111, 10, 0, 100, 3'b010, 0,  3'b000, 3'b010, 1'b0, 100,     1};
    tbl[2] = '{"seq_ev2",      3'b111, 10, 0, 100, 3'b100, 0,  3'b000, 3'b100, 1'b0, 100,     0};
    tbl[3] = '{"delay_edge",   3'b001, 5,  0, 5,   3'b001, 9,  3'b001, 3'b001, 1'b0, EDGE_EK, 0};
    tbl[4] = '{"timeout4",     3'b111, 2,  4, 0,   3'b000, 0,  3'b000, 3'b000, 1'b1, 6,       2};
    tbl[5] = '{"hit_at_expiry",3'b111, 2,  4, 6,   3'b010, 0,  3'b000, 3'b010, 1'b0, 6,       0};
    tbl[6] = '{"multi_hot_bp", 3'b101, 1,  0, 3,   3'b010, 5,  3'b111, 3'b101, 1'b0, 5,       20};

    rst = 1'b1; ev_i = '0; arm_valid = 1'b0; arm_mask = '0;
    arm_delay = '0; arm_timeout = '0; done_ready = 1'b0;
    tick();
    tick();
    check("reset_in_rst", {26'd0, arm_ready, done_valid, done_hit[0], done_timeout, busy, |rounds},
          32'b100000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("reset_ready", 32'(arm_ready), 32'd1);
    check("reset_outputs", {24'd0, done_valid, done_hit, done_timeout, busy, rounds}, 32'd0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      clear_seq();
      if (tbl[i].k1 > 0) ev_seq[tbl[i].k1] = tbl[i].v1;
      if (tbl[i].k2 > 0) ev_seq[tbl[i].k2] = tbl[i].v2;
      do_round(tbl[i].name, tbl[i].m, tbl[i].d, tbl[i].t, tbl[i].ehit, tbl[i].eto,
               tbl[i].ek, tbl[i].hold);
      if (i == 2) check("three_rounds", 32'(rounds), 32'd3);
      if (i == 4) check("wrap_after_5", 32'(rounds), 32'd1);
    end

    // Reset asserted between edges while in WAIT
    arm_valid = 1'b1; arm_mask = 3'b001; arm_delay = '0; arm_timeout = '0;
    tick();
    arm_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {28'd0, busy, done_valid, |rounds, arm_ready}, 32'b0001);
    @(negedge clk);
    rst = 1'b0;
    exp_rounds = 0;
    tick();
    check("post_reset_rounds", 32'(rounds), 32'd0);

    // Randomized rounds against the schedule model
    for (int r = 0; r < 30; r++) begin
      clear_seq();
      m = N'($urandom_range(1, 7));
      d = $urandom_range(0, 6);
      t = $urandom_range(0, 12);
      for (int k = 0; k <= 50; k++)
        if ($urandom_range(0, 3) == 0) ev_seq[k] = N'($urandom);
      if (t == 0) ev_seq[50] = ev_seq[50] | m;
      model(m, d, t, ek, h, to);
      if (ek < 0) begin
        failures++;
        $display("FAIL rand_model: round %0d never completes", r);
      end else begin
        do_round($sformatf("rand%0d", r), m, d, t, h, to, ek, $urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
